// File: rtl/ac_snoop_scheduler.sv
// ac_snoop_scheduler: round-robin ACE snoop broadcaster.
// One originator is granted at a time. Its snoop is broadcast on the AC
// channel to every other master, all CR responses are collected and ORed,
// and a one-cycle completion pulse is returned to the originator.
module ac_snoop_scheduler #(
   parameter int NUM_M    = 8,
   parameter int CRRESP_W = 5
) (
   input  logic                        ACLK,
   input  logic                        ARESET,
   input  logic [NUM_M-1:0]            snoop_req,
   input  logic [NUM_M-1:0]            snoop_is_wr,
   output logic [2*NUM_M-1:0]          mux_sel,
   output logic [NUM_M-1:0]            ACVALID,
   input  logic [NUM_M-1:0]            ACREADY,
   input  logic [NUM_M-1:0]            CRVALID,
   output logic [NUM_M-1:0]            CRREADY,
   input  logic [NUM_M*CRRESP_W-1:0]   CRRESP,
   output logic [NUM_M-1:0]            snoop_done,
   output logic [CRRESP_W-1:0]         snoop_resp,
   output logic                        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // One-hot decode of a master index.
   function automatic logic [NUM_M-1:0] onehot(input logic [2:0] idx);
      logic [NUM_M-1:0] v;
      v      = {NUM_M{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first requester found searching upward from ptr+1.
   // Iterating from the lowest priority slot down lets the last hit win.
   function automatic logic [2:0] rr_pick(input logic [NUM_M-1:0] req,
                                          input logic [2:0]       ptr);
      logic [2:0] pick;
      logic [2:0] idx;
      pick = 3'd0;
      for (int i = NUM_M; i >= 1; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) begin
            pick = idx;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // OR together the CRRESP fields of every master handshaking this cycle.
   function automatic logic [CRRESP_W-1:0] collect(input logic [NUM_M-1:0]          hs,
                                                   input logic [NUM_M*CRRESP_W-1:0] resp);
      logic [CRRESP_W-1:0] r;
      r = {CRRESP_W{1'b0}};
      for (int j = 0; j < NUM_M; j++) begin
         if (hs[j]) begin
            r = r | resp[j*CRRESP_W +: CRRESP_W];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   state_e                state_q,    state_d;
   logic [2:0]            gnt_q,      gnt_d;
   logic [2:0]            rr_ptr_q,   rr_ptr_d;
   logic [NUM_M-1:0]      ac_pend_q,  ac_pend_d;
   logic [NUM_M-1:0]      cr_pend_q,  cr_pend_d;
   logic [CRRESP_W-1:0]   acc_q,      acc_d;
   logic [2*NUM_M-1:0]    mux_sel_q,  mux_sel_d;
   logic [NUM_M-1:0]      done_q,     done_d;
   logic [CRRESP_W-1:0]   resp_q,     resp_d;
   logic                  busy_q,     busy_d;

   logic [2:0]            pick_s;
   logic [NUM_M-1:0]      pick_oh_s;
   logic [NUM_M-1:0]      ac_hs_s;
   logic [NUM_M-1:0]      cr_hs_s;

   assign pick_s    = rr_pick(snoop_req, rr_ptr_q);
   assign pick_oh_s = onehot(pick_s);
   // The pending masks are zero outside their own state, so they drive the
   // handshake outputs directly.
   assign ac_hs_s   = ac_pend_q & ACREADY;
   assign cr_hs_s   = cr_pend_q & CRVALID;

   // Next-state and next-output logic of the snoop FSM.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_ptr_d  = rr_ptr_q;
      ac_pend_d = ac_pend_q;
      cr_pend_d = cr_pend_q;
      acc_d     = acc_q;
      mux_sel_d = mux_sel_q;
      done_d    = {NUM_M{1'b0}};
      resp_d    = {CRRESP_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (|snoop_req) begin
               state_d   = ST_ADDR;
               gnt_d     = pick_s;
               ac_pend_d = ~pick_oh_s;
               if (snoop_is_wr[pick_s]) begin
                  mux_sel_d = {pick_oh_s, {NUM_M{1'b0}}};
               end else begin
                  mux_sel_d = {{NUM_M{1'b0}}, pick_oh_s};
               end
            end else begin
               mux_sel_d = {2*NUM_M{1'b0}};
            end
         end
         ST_ADDR: begin
            ac_pend_d = ac_pend_q & ~ac_hs_s;
            if (ac_pend_d == {NUM_M{1'b0}}) begin
               state_d   = ST_RESP;
               cr_pend_d = ~onehot(gnt_q);
            end else begin
               state_d   = ST_ADDR;
            end
         end
         ST_RESP: begin
            cr_pend_d = cr_pend_q & ~cr_hs_s;
            acc_d     = acc_q | collect(cr_hs_s, CRRESP);
            if (cr_pend_d == {NUM_M{1'b0}}) begin
               state_d   = ST_DONE;
               mux_sel_d = {2*NUM_M{1'b0}};
               done_d    = onehot(gnt_q);
               resp_d    = acc_d;
            end else begin
               state_d   = ST_RESP;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            rr_ptr_d = gnt_q;
            acc_d    = {CRRESP_W{1'b0}};
         end
         default: begin
            state_d   = ST_IDLE;
            ac_pend_d = {NUM_M{1'b0}};
            cr_pend_d = {NUM_M{1'b0}};
            acc_d     = {CRRESP_W{1'b0}};
            mux_sel_d = {2*NUM_M{1'b0}};
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset abandons any snoop in flight.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 3'd0;
         rr_ptr_q  <= 3'd7;
         ac_pend_q <= {NUM_M{1'b0}};
         cr_pend_q <= {NUM_M{1'b0}};
         acc_q     <= {CRRESP_W{1'b0}};
         mux_sel_q <= {2*NUM_M{1'b0}};
         done_q    <= {NUM_M{1'b0}};
         resp_q    <= {CRRESP_W{1'b0}};
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_ptr_q  <= rr_ptr_d;
         ac_pend_q <= ac_pend_d;
         cr_pend_q <= cr_pend_d;
         acc_q     <= acc_d;
         mux_sel_q <= mux_sel_d;
         done_q    <= done_d;
         resp_q    <= resp_d;
         busy_q    <= busy_d;
      end
   end

   assign mux_sel    = mux_sel_q;
   assign ACVALID    = ac_pend_q;
   assign CRREADY    = cr_pend_q;
   assign snoop_done = done_q;
   assign snoop_resp = resp_q;
   assign busy       = busy_q;

endmodule

// File: doc/ac_snoop_scheduler.md
AC_SNOOP_SCHEDULER -- requirements
Module: ac_snoop_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_M, default 8, meaning the number of ACE masters; the mux_sel encoding fixes it at 8.
REQ-002 The block SHALL have parameter CRRESP_W, default 5, meaning the CRRESP width per master.
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port snoop_req, input, 8 bits: master i requests a snoop broadcast; level, held until snoop_done[i].
REQ-006 The block SHALL have port snoop_is_wr, input, 8 bits: 1 means request i is write-originated; sampled at grant.
REQ-007 The block SHALL have port mux_sel, output, 16 bits: one-hot AC-mux select; bit g for a read-originated grant, bit 8+g for a write-originated grant, all-zero when idle.
REQ-008 The block SHALL have port ACVALID, output, 8 bits: per-snoopee AC valid.
REQ-009 The block SHALL have port ACREADY, input, 8 bits: per-snoopee AC ready.
REQ-010 The block SHALL have port CRVALID, input, 8 bits: per-snoopee snoop-response valid.
REQ-011 The block SHALL have port CRREADY, output, 8 bits: per-snoopee snoop-response ready.
REQ-012 The block SHALL have port CRRESP, input, 8*CRRESP_W bits: master j response in bits [j*5+4:j*5].
REQ-013 The block SHALL have port snoop_done, output, 8 bits: one-cycle completion pulse to the originator.
REQ-014 The block SHALL have port snoop_resp, output, CRRESP_W bits: bitwise OR of all collected CRRESP, valid while snoop_done is nonzero.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The block SHALL implement the states IDLE, ADDR, RESP, DONE in a registered FSM.
REQ-017 In IDLE, when snoop_req is nonzero, the block SHALL grant g by round-robin, searching upward from rr_ptr+1 modulo 8, and go to ADDR.
REQ-018 The block SHALL latch g and snoop_is_wr[g] at grant, so mux_sel is one-hot in the first ADDR cycle (request-to-mux_sel latency of 1 cycle).
REQ-019 The block SHALL hold mux_sel constant through ADDR and RESP and clear it to zero in DONE.
REQ-020 On entry to ADDR, the block SHALL load ac_pend = 8'hFF with bit g cleared, so the originator is never snooped.
REQ-021 The block SHALL drive ACVALID = ac_pend in ADDR; ac_pend[j] SHALL clear on the cycle ACVALID[j] & ACREADY[j]; ACVALID[j] SHALL never drop before its handshake.
REQ-022 When ac_pend becomes zero, the block SHALL go to RESP next cycle and load cr_pend = 8'hFF with bit g cleared.
REQ-023 The block SHALL drive CRREADY = cr_pend in RESP only, so a CRVALID asserted during ADDR waits.
REQ-024 On CRVALID[j] & CRREADY[j], the block SHALL clear cr_pend[j] and OR CRRESP[j] into the accumulator.
REQ-025 Handshakes from several masters in the same cycle SHALL all be accepted and accumulated in that cycle.
REQ-026 When cr_pend becomes zero, the block SHALL go to DONE.
REQ-027 In DONE, for exactly one cycle, the block SHALL assert snoop_done[g] and drive snoop_resp = accumulator, then set rr_ptr = g, clear the accumulator and return to IDLE.
REQ-028 The block SHALL ignore snoop_req during ADDR, RESP and DONE; requests arriving there SHALL be arbitrated in the next IDLE.
REQ-029 A request still held by g in IDLE after DONE SHALL be treated as a new request at lowest priority.
REQ-030 The minimum snoop, with all ready/valid asserted, SHALL be 4 cycles grant-to-grant: IDLE, ADDR, RESP, DONE.
REQ-031 The block SHALL assert ACVALID and CRREADY only in their own states, and assert each at most on non-originator bits.

Reset
REQ-032 On ARESET=1, asynchronously, the block SHALL set the FSM to IDLE, mux_sel, ACVALID, CRREADY, snoop_done, snoop_resp, ac_pend, cr_pend and the accumulator to 0, busy to 0, and rr_ptr to 7 (master 0 has first priority).
REQ-033 Reset mid-snoop SHALL abandon the transaction with no snoop_done pulse.
REQ-034 After release, the block SHALL arbitrate on the first rising edge that sees ARESET=0.

Verification
REQ-035 The bench SHALL cover: after reset, snoop_req=8'h01, snoop_is_wr=0, all ACREADY/CRVALID=1, CRRESP all 0 -> mux_sel=16'h0001 and ACVALID=8'hFE for 1 cycle, CRREADY=8'hFE for 1 cycle, snoop_done=8'h01 on cycle 4.
REQ-036 The bench SHALL cover: snoop_req=8'h08, snoop_is_wr=8'h08 -> mux_sel=16'h0800, ACVALID=8'hF7.
REQ-037 The bench SHALL cover: snoop_req=8'h81 held continuously -> grants 0,7,0,7 in turn, each snoop_done one cycle.
REQ-038 The bench SHALL cover: ACREADY bits arriving staggered over 7 cycles -> each ACVALID bit drops individually and RESP is entered only after the last handshake.
REQ-039 The bench SHALL cover: master 2 CRRESP=5'b00001 and master 5 CRRESP=5'b01000, others 0 -> snoop_resp=5'b01001 in the DONE cycle.
REQ-040 The bench SHALL cover: ARESET pulsed during RESP -> all outputs 0 immediately, no snoop_done, and the next grant is master 0 if it is requesting.
